hsid_fifo_ctrl: RTL

Sequencer for one hsid_fifo instance used as a reference-spectrum replay buffer. It clears the FIFO, loads a reference vector of vector_len bands from a valid/ready source, then enables loop mode and replays the vector pixel_count times to a downstream valid/ready consumer. It sits between the reference loader and the distance datapath and owns all FIFO control pins.

---
 rtl/hsid_pkg.sv | 19 +
 rtl/hsid_fifo.sv | 78 +++++++
 rtl/hsid_replay_cnt.sv | 45 ++++
 rtl/hsid_fifo_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hsid_pkg.sv
// Shared types and helpers for the hsid reference-replay blocks.
package hsid_pkg;

  localparam int HSID_PIXEL_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    STREAM,
    FLUSH
  } hsid_fifo_ctrl_state_e;

  // Width needed to hold an element count from 0 up to and including depth.
  function automatic int hsid_band_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hsid_fifo.sv
// Circular FIFO with loop mode: a read in loop mode re-enqueues the element
// it pops, so the contents rotate instead of draining. Read data is
// registered and held until the next read.
module hsid_fifo
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  loop_en,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = hsid_band_w(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_rd;
  logic                  do_wr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en & ~empty;
  // A read owns the write port (recirculation), so a same-cycle write is dropped.
  assign do_wr = wr_en & ~full & ~do_rd;

  // Pointer, occupancy and registered read-data bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (do_rd) begin
      data_out <= mem[rd_ptr];
      rd_ptr   <= next_ptr(rd_ptr);
      if (loop_en) begin
        wr_ptr <= next_ptr(wr_ptr);
      end else begin
        count <= count - CNT_W'(1);
      end
    end else if (do_wr) begin
      wr_ptr <= next_ptr(wr_ptr);
      count  <= count + CNT_W'(1);
    end
  end

  // Storage array: external writes, or the popped element copied to the tail.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (do_rd && loop_en) begin
        mem[wr_ptr] <= mem[rd_ptr];
      end else if (do_wr) begin
        mem[wr_ptr] <= data_in;
      end
    end
  end

endmodule

// File: rtl/hsid_replay_cnt.sv
// Nested band/pixel position counter for the replay stream. It advances
// once per accepted beat; the band count wraps at the last band and carries
// into the pixel count.
module hsid_replay_cnt #(
  parameter int BAND_W  = 5,
  parameter int PIXEL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  input  logic [BAND_W-1:0]  vector_len,
  input  logic [PIXEL_W-1:0] pixel_count,
  output logic               last_band,
  output logic               last_pixel
);

  logic [BAND_W-1:0]  band_cnt;
  logic [PIXEL_W-1:0] pix_cnt;

  // Compare count+1 against the limit so a zero limit never underflows.
  assign last_band  = ((BAND_W + 1)'(band_cnt) + (BAND_W + 1)'(1)) ==
                      (BAND_W + 1)'(vector_len);
  assign last_pixel = ((PIXEL_W + 1)'(pix_cnt) + (PIXEL_W + 1)'(1)) ==
                      (PIXEL_W + 1)'(pixel_count);

  // Band count with wrap, carrying into the pixel count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      band_cnt <= '0;
      pix_cnt  <= '0;
    end else if (clr) begin
      band_cnt <= '0;
      pix_cnt  <= '0;
    end else if (adv) begin
      if (last_band) begin
        band_cnt <= '0;
        pix_cnt  <= pix_cnt + PIXEL_W'(1);
      end else begin
        band_cnt <= band_cnt + BAND_W'(1);
      end
    end
  end

endmodule

// File: rtl/hsid_fifo_ctrl.sv
// Sequencer for an hsid_fifo used as a reference-spectrum replay buffer:
// clear, load vector_len bands, then replay them pixel_count times in loop
// mode to a valid/ready consumer, and clear again on completion or abort.
module hsid_fifo_ctrl
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int BAND_W     = hsid_band_w(FIFO_DEPTH),
  parameter int PIXEL_W    = HSID_PIXEL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [BAND_W-1:0]     vector_len,
  input  logic [PIXEL_W-1:0]    pixel_count,
  input  logic                  ref_valid,
  input  logic [DATA_WIDTH-1:0] ref_data,
  output logic                  ref_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  out_last_band,
  output logic                  out_last_pixel,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  output logic                  fifo_loop_en,
  output logic                  fifo_clear,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_full,
  input  logic                  fifo_empty
);

  localparam int                TOT_W   = BAND_W + PIXEL_W;
  localparam logic [BAND_W-1:0] DEPTH_B = BAND_W'(FIFO_DEPTH);

  hsid_fifo_ctrl_state_e state_q;
  hsid_fifo_ctrl_state_e state_nxt;

  logic [BAND_W-1:0]  cfg_len;
  logic [PIXEL_W-1:0] cfg_pix;
  logic [TOT_W-1:0]   total;
  logic [TOT_W-1:0]   issued;
  logic [BAND_W-1:0]  load_cnt;

  logic cfg_ok;
  logic cfg_take;
  logic accept;
  logic adv;
  logic aborting;
  logic last_band;
  logic last_pixel;

  assign cfg_ok   = (vector_len != '0) && (vector_len <= DEPTH_B) &&
                    (pixel_count != '0);
  assign accept   = out_valid & out_ready;
  assign aborting = abort & (state_q != IDLE);

  assign busy           = (state_q != IDLE);
  assign out_data       = fifo_data_out;
  assign fifo_data_in   = ref_data;
  assign out_last_band  = out_valid & last_band;
  assign out_last_pixel = out_valid & last_pixel;

  // Next-state and FIFO/handshake control; abort overrides every handshake.
  always_comb begin
    state_nxt    = state_q;
    ref_ready    = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_rd_en   = 1'b0;
    fifo_loop_en = 1'b0;
    fifo_clear   = 1'b0;
    done         = 1'b0;
    cfg_err      = 1'b0;
    cfg_take     = 1'b0;
    adv          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            cfg_take  = 1'b1;
            state_nxt = CLEAR;
          end else begin
            cfg_err = 1'b1;
          end
        end
      end
      CLEAR: begin
        fifo_clear = 1'b1;
        state_nxt  = LOAD;
      end
      LOAD: begin
        if (load_cnt == cfg_len) begin
          state_nxt = STREAM;
        end else begin
          ref_ready = ~fifo_full;
        end
      end
      STREAM: begin
        fifo_loop_en = 1'b1;
        fifo_rd_en   = (~out_valid | out_ready) & (issued < total) & ~fifo_empty;
        adv          = accept;
        if (accept && last_band && last_pixel) begin
          done      = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        fifo_clear = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (aborting) begin
      state_nxt  = FLUSH;
      ref_ready  = 1'b0;
      fifo_rd_en = 1'b0;
      adv        = 1'b0;
      done       = 1'b0;
    end
    fifo_wr_en = ref_valid & ref_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Latched run configuration; the beat total is formed once during CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_len <= '0;
      cfg_pix <= '0;
      total   <= '0;
    end else begin
      if (cfg_take) begin
        cfg_len <= vector_len;
        cfg_pix <= pixel_count;
      end
      if (state_q == CLEAR) begin
        total <= TOT_W'(cfg_len) * TOT_W'(cfg_pix);
      end
    end
  end

  // Load and issue counters, restarted on every CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
      issued   <= '0;
    end else if (state_q == CLEAR) begin
      load_cnt <= '0;
      issued   <= '0;
    end else begin
      if (fifo_wr_en) begin
        load_cnt <= load_cnt + BAND_W'(1);
      end
      if (fifo_rd_en) begin
        issued <= issued + TOT_W'(1);
      end
    end
  end

  // Output valid follows the FIFO's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (aborting || state_q == FLUSH) begin
      out_valid <= 1'b0;
    end else if (fifo_rd_en) begin
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  hsid_replay_cnt #(
    .BAND_W  (BAND_W),
    .PIXEL_W (PIXEL_W)
  ) u_replay_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (state_q == CLEAR),
    .adv         (adv),
    .vector_len  (cfg_len),
    .pixel_count (cfg_pix),
    .last_band   (last_band),
    .last_pixel  (last_pixel)
  );

endmodule
